// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch with run/pause/clear/adjust driven by divider ticks.
// Optional ADJ_BLINK_EN builds a 4 Hz blink of the field being adjusted.
module stopwatch_core #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_hz_tick,
  input  logic       two_hz_tick,
  input  logic       four_hz_tick,
  input  logic       pause_btn,
  input  logic       clr_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running
);
  typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_t;
  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_MIN % 10);
  state_t state_q, state_d;
  logic resume_q, resume_d, running_q;
  logic [3:0] mt_q, mo_q, st_q, so_q, mt_d, mo_d, st_d, so_d;
  logic inc_sec, inc_min, sec_wrap, min_wrap;
  always_comb begin
    sec_wrap = st_q == 4'd5 && so_q == 4'd9;
    min_wrap = mt_q == MAX_T && mo_q == MAX_O;
    // adjusting seconds never carries; only RUN rolls 59 into minutes
    inc_sec = (state_q == RUN && one_hz_tick) || (state_q == ADJUST && two_hz_tick && sel);
    inc_min = (state_q == RUN && one_hz_tick && sec_wrap) || (state_q == ADJUST && two_hz_tick && !sel);
    so_d = clr_btn ? 4'd0 : !inc_sec ? so_q : so_q == 4'd9 ? 4'd0 : so_q + 4'd1;
    st_d = clr_btn ? 4'd0 : !(inc_sec && so_q == 4'd9) ? st_q : st_q == 4'd5 ? 4'd0 : st_q + 4'd1;
    mo_d = clr_btn ? 4'd0 : !inc_min ? mo_q : (min_wrap || mo_q == 4'd9) ? 4'd0 : mo_q + 4'd1;
    mt_d = clr_btn ? 4'd0 : !inc_min ? mt_q : min_wrap ? 4'd0 : mo_q == 4'd9 ? mt_q + 4'd1 : mt_q;
    state_d = state_q == ADJUST ? (adj ? ADJUST : resume_q ? RUN : PAUSED)
            : adj ? ADJUST
            : pause_btn ? (state_q == RUN ? PAUSED : RUN) : state_q;
    resume_d = (state_q != ADJUST && adj) ? state_q == RUN : resume_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PAUSED;
      resume_q  <= 1'b0;
      running_q <= 1'b0;
      {mt_q, mo_q, st_q, so_q} <= '0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      running_q <= state_d == RUN;
      {mt_q, mo_q, st_q, so_q} <= {mt_d, mo_d, st_d, so_d};
    end
  end
`ifdef ADJ_BLINK_EN
  logic phase_q, phase_d, blank_min_q, blank_sec_q;
  // phase restarts at 0 whenever ADJUST is entered
  assign phase_d = state_q != ADJUST ? 1'b0 : phase_q ^ four_hz_tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= 1'b0;
      blank_min_q <= 1'b0;
      blank_sec_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      blank_min_q <= state_d == ADJUST && !sel && phase_d;
      blank_sec_q <= state_d == ADJUST && sel && phase_d;
    end
  end
  assign blank_min = blank_min_q;
  assign blank_sec = blank_sec_q;
`else
  logic unused_four_hz;
  assign unused_four_hz = four_hz_tick;
  assign blank_min = 1'b0;
  assign blank_sec = 1'b0;
`endif
  assign {min_tens, min_ones, sec_tens, sec_ones} = {mt_q, mo_q, st_q, so_q};
  assign running = running_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed and random stimulus against a seconds-count model of the stopwatch.
module tb_stopwatch_core;
  localparam int MAXM = 99;
  logic clk = 0, rst = 0;
  logic one_hz_tick = 0, two_hz_tick = 0, four_hz_tick = 0, pause_btn = 0, clr_btn = 0, adj = 0, sel = 0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic blank_min, blank_sec, running;
  int errors = 0, checks = 0;
  bit chk_en = 0;

  stopwatch_core #(.MAX_MIN(MAXM)) dut (
    .clk(clk), .rst(rst), .one_hz_tick(one_hz_tick), .two_hz_tick(two_hz_tick),
    .four_hz_tick(four_hz_tick), .pause_btn(pause_btn), .clr_btn(clr_btn), .adj(adj), .sel(sel),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blank_min(blank_min), .blank_sec(blank_sec), .running(running)
  );

  always #5 clk = ~clk;

  // model: time kept as total seconds, mode as run/adjust flags
  int m_t = 0;
  bit m_run = 0, m_adj = 0, m_res = 0, m_ph = 0, e_bm = 0, e_bs = 0;
`ifdef ADJ_BLINK_EN
  localparam bit BLINK = 1;
`else
  localparam bit BLINK = 0;
`endif

  always @(posedge clk or posedge rst) begin : model
    int t, mm, ss;
    bit ad, rn, rs, ph;
    if (rst) begin
      m_t <= 0; m_run <= 0; m_adj <= 0; m_res <= 0; m_ph <= 0; e_bm <= 0; e_bs <= 0;
    end else begin
      t = m_t; mm = t / 60; ss = t % 60; ad = m_adj; rn = m_run; rs = m_res; ph = m_ph;
      if (clr_btn) t = 0;
      else if (ad && two_hz_tick) t = sel ? mm * 60 + (ss + 1) % 60 : ((mm + 1) % (MAXM + 1)) * 60 + ss;
      else if (!ad && rn && one_hz_tick) t = (t + 1) % ((MAXM + 1) * 60);
      if (ad) begin
        ph = ph ^ four_hz_tick;
        if (!adj) begin ad = 0; rn = rs; end
      end else if (adj) begin
        ad = 1; rs = rn; ph = 0;
      end else if (pause_btn) rn = !rn;
      if (!BLINK) ph = 0;
      m_t <= t; m_run <= rn; m_adj <= ad; m_res <= rs; m_ph <= ph;
      e_bm <= ad && !sel && ph;
      e_bs <= ad && sel && ph;
    end
  end

  function automatic int tv();
    return min_tens * 1000 + min_ones * 100 + sec_tens * 10 + sec_ones;
  endfunction
  function automatic int mtv(input int t);
    return (t / 600) * 1000 + ((t / 60) % 10) * 100 + ((t % 60) / 10) * 10 + t % 10;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en && !rst) begin
    chk("model_time", tv(), mtv(m_t));
    chk("model_running", int'(running), int'(m_run && !m_adj));
    chk("model_blank_min", int'(blank_min), int'(e_bm));
    chk("model_blank_sec", int'(blank_sec), int'(e_bs));
  end

  task automatic step(input bit o, input bit t, input bit f, input bit p, input bit c);
    one_hz_tick = o; two_hz_tick = t; four_hz_tick = f; pause_btn = p; clr_btn = c;
    @(posedge clk); #1;
    {one_hz_tick, two_hz_tick, four_hz_tick, pause_btn, clr_btn} = '0;
  endtask
  task automatic ticks(input int n, input bit o, input bit t);
    for (int i = 0; i < n; i++) step(o, t, 0, 0, 0);
  endtask

  initial begin
    int bexp[4];
    bexp = '{1, 0, 1, 0};
    #2 rst = 1;
    @(posedge clk); @(posedge clk); #1 rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_time", tv(), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_blank", int'({blank_min, blank_sec}), 0);
    ticks(3, 1, 0);
    @(negedge clk) chk("paused_ignores_ticks", tv(), 0);
    step(0, 0, 0, 1, 0);
    @(negedge clk) chk("pause_to_run", int'(running), 1);
    ticks(61, 1, 0);
    @(negedge clk) chk("count_61", tv(), 101);
    chk("model_pin_61", m_t, 61);
    // preset 99:59 through adjust while running
    step(0, 0, 0, 0, 1);
    adj = 1; sel = 0; step(0, 0, 0, 0, 0);
    ticks(MAXM, 0, 1);
    sel = 1; ticks(59, 0, 1);
    @(negedge clk) chk("preset_9959", tv(), 9959);
    adj = 0; step(0, 0, 0, 0, 0);
    @(negedge clk) chk("resume_run", int'(running), 1);
    step(1, 0, 0, 0, 0);
    @(negedge clk) chk("full_wrap", tv(), 0);
    ticks(10, 1, 0);
    step(1, 0, 0, 1, 0);
    @(negedge clk) chk("pause_with_tick_time", tv(), 11);
    chk("pause_with_tick_run", int'(running), 0);
    ticks(3, 1, 0);
    @(negedge clk) chk("paused_hold", tv(), 11);
    adj = 1; sel = 1; step(0, 0, 0, 0, 0);
    ticks(47, 0, 1);
    @(negedge clk) chk("adj_to_58", tv(), 58);
    ticks(3, 0, 1);
    @(negedge clk) chk("adj_sec_wrap_no_carry", tv(), 1);
    adj = 0; step(0, 0, 0, 0, 0);
    @(negedge clk) chk("resume_paused", int'(running), 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    adj = 1; sel = 0; step(0, 0, 0, 0, 0);
    ticks(12, 0, 1);
    sel = 1; ticks(34, 0, 1);
    adj = 0; step(0, 0, 0, 0, 0);
    @(negedge clk) chk("preset_1234", tv(), 1234);
    step(1, 0, 0, 0, 1);
    @(negedge clk) chk("clr_priority", tv(), 0);
    chk("clr_keeps_run", int'(running), 1);
    adj = 1; sel = 0; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 0);
      @(negedge clk);
      chk("blink_min", int'(blank_min), BLINK ? bexp[i] : 0);
      chk("blink_sec", int'(blank_sec), 0);
    end
    adj = 0; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(31) == 0) adj = !adj;
      if ($urandom_range(15) == 0) sel = !sel;
      step($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
           $urandom_range(15) == 0, $urandom_range(63) == 0);
    end
    adj = 0; step(0, 0, 0, 0, 0);
    if (!m_run) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    ticks(5, 1, 0);
    #2 rst = 1;
    #1 chk("async_rst_time", tv(), 0);
    chk("async_rst_running", int'(running), 0);
    @(posedge clk); @(posedge clk); #1 rst = 0;
    ticks(2, 1, 0);
    @(negedge clk) chk("post_rst_paused", tv(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
